// File: rtl/maq_refri_pkg.sv
// rtl/maq_refri_pkg.sv - coin encodings, coin values and FSM state type for the vend/change sequencer
package maq_refri_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

  // Value in cents of a coin code; COIN_NONE is worth nothing.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_25: return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/maq_refri_seq_if.sv
// rtl/maq_refri_seq_if.sv - coin, dispenser and change-hopper signals of the sequencer
interface maq_refri_seq_if #(
  parameter int CREDIT_W = 7
);

  logic [1:0]          moeda;
  logic                cancel;
  logic                dispense_ack;
  logic                change_ack;
  logic                dispense_req;
  logic                change_req;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                busy;

  // Machine side: coin acceptor, cancel button and actuators.
  modport master (
    output moeda, cancel, dispense_ack, change_ack,
    input  dispense_req, change_req, change_coin, credit, coin_reject, busy
  );

  // Sequencer side.
  modport slave (
    input  moeda, cancel, dispense_ack, change_ack,
    output dispense_req, change_req, change_coin, credit, coin_reject, busy
  );

endinterface

// File: rtl/maq_refri_coin_dec.sv
// rtl/maq_refri_coin_dec.sv - coin bus edge detector producing one event per inserted coin
module maq_refri_coin_dec
  import maq_refri_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moeda,
  output logic       coin_evt,
  output logic [4:0] coin_val
);

  logic [1:0] moeda_q;

  // Previous-cycle coin code; a coin only counts when it follows an idle bus.
  always_ff @(posedge clk) begin
    if (rst) moeda_q <= COIN_NONE;
    else     moeda_q <= moeda;
  end

  // Code-to-code changes without an idle cycle in between are not new coins.
  assign coin_evt = (moeda != COIN_NONE) && (moeda_q == COIN_NONE);
  assign coin_val = coin_value(moeda);

endmodule

// File: rtl/maq_refri_seq.sv
// rtl/maq_refri_seq.sv - vend/change sequencer: credit accumulation, dispense and change handshakes
module maq_refri_seq
  import maq_refri_pkg::*;
#(
  parameter int PRICE      = 20,
  parameter int CREDIT_W   = 7,
  parameter int MAX_CREDIT = 95
) (
  input logic            clk,
  input logic            rst,
  maq_refri_seq_if.slave bus
);

  localparam int                  W1      = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [W1-1:0]       MAX_C   = W1'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic                dispense_req_q;
  logic                change_req_q;
  logic [1:0]          change_coin_q;
  logic                coin_reject_q;
  logic                busy_q;

  logic                coin_evt;
  logic [4:0]          coin_val;
  logic [W1-1:0]       sum;
  logic                coin_fits;
  logic [1:0]          pick;
  logic [CREDIT_W-1:0] rem;

  maq_refri_coin_dec u_dec (
    .clk      (clk),
    .rst      (rst),
    .moeda    (bus.moeda),
    .coin_evt (coin_evt),
    .coin_val (coin_val)
  );

  // One extra bit so a large credit plus a coin cannot wrap below the cap.
  assign sum       = {1'b0, credit_q} + W1'(coin_val);
  assign coin_fits = (sum <= MAX_C);
  assign rem       = credit_q - CREDIT_W'(coin_value(change_coin_q));

  // Greedy change: largest coin that still fits in the remaining credit.
  always_comb begin
    pick = COIN_5;
    if (credit_q >= CREDIT_W'(25))      pick = COIN_25;
    else if (credit_q >= CREDIT_W'(10)) pick = COIN_10;
  end

  // Sequencer FSM with credit datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      credit_q       <= '0;
      dispense_req_q <= 1'b0;
      change_req_q   <= 1'b0;
      change_coin_q  <= COIN_NONE;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_evt) begin
            if (coin_fits) begin
              credit_q <= sum[CREDIT_W-1:0];
              state    <= ACCUM;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          // The vend wins; a coin landing on the same cycle is handed back.
          if (credit_q >= PRICE_C) begin
            credit_q       <= credit_q - PRICE_C;
            dispense_req_q <= 1'b1;
            busy_q         <= 1'b1;
            coin_reject_q  <= coin_evt;
            state          <= VEND;
          end else if (coin_evt) begin
            if (coin_fits) credit_q <= sum[CREDIT_W-1:0];
            else           coin_reject_q <= 1'b1;
          end else if (bus.cancel && credit_q != '0) begin
            busy_q        <= 1'b1;
            change_req_q  <= 1'b1;
            change_coin_q <= pick;
            state         <= CHANGE;
          end
        end
        VEND: begin
          coin_reject_q <= coin_evt;
          if (bus.dispense_ack) begin
            dispense_req_q <= 1'b0;
            if (credit_q != '0) begin
              change_req_q  <= 1'b1;
              change_coin_q <= pick;
              state         <= CHANGE;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject_q <= coin_evt;
          if (change_req_q) begin
            if (bus.change_ack) begin
              credit_q      <= rem;
              change_req_q  <= 1'b0;
              change_coin_q <= COIN_NONE;
              if (rem == '0) begin
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            end
          end else begin
            // One idle cycle after each ack, then present the next coin.
            change_req_q  <= 1'b1;
            change_coin_q <= pick;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense_req = dispense_req_q;
  assign bus.change_req   = change_req_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_maq_refri_seq.sv
// tb/tb_maq_refri_seq.sv - self-checking bench for the vend/change sequencer
module tb_maq_refri_seq;
  import maq_refri_pkg::*;

  localparam int MAXC = 95;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] moeda = 2'b00;
  logic       cancel = 1'b0;
  logic       dispense_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic       sel = 1'b0;
  int         cur_price = 20;
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_credit = 0;
  int         val_tab[4] = '{0, 5, 10, 25};

  maq_refri_seq_if #(.CREDIT_W(7)) bus_a ();
  maq_refri_seq_if #(.CREDIT_W(7)) bus_b ();

  maq_refri_seq #(.PRICE(20), .CREDIT_W(7), .MAX_CREDIT(95)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  // Second copy priced out of reach, so credit can climb to the cap.
  maq_refri_seq #(.PRICE(100), .CREDIT_W(7), .MAX_CREDIT(95)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_a.moeda        = sel ? 2'b00 : moeda;
  assign bus_a.cancel       = sel ? 1'b0  : cancel;
  assign bus_a.dispense_ack = sel ? 1'b0  : dispense_ack;
  assign bus_a.change_ack   = sel ? 1'b0  : change_ack;
  assign bus_b.moeda        = sel ? moeda        : 2'b00;
  assign bus_b.cancel       = sel ? cancel       : 1'b0;
  assign bus_b.dispense_ack = sel ? dispense_ack : 1'b0;
  assign bus_b.change_ack   = sel ? change_ack   : 1'b0;

  logic [6:0] o_credit;
  logic       o_disp_req, o_chg_req, o_reject, o_busy;
  logic [1:0] o_chg_coin;
  assign o_credit   = sel ? bus_b.credit       : bus_a.credit;
  assign o_disp_req = sel ? bus_b.dispense_req : bus_a.dispense_req;
  assign o_chg_req  = sel ? bus_b.change_req   : bus_a.change_req;
  assign o_chg_coin = sel ? bus_b.change_coin  : bus_a.change_coin;
  assign o_reject   = sel ? bus_b.coin_reject  : bus_a.coin_reject;
  assign o_busy     = sel ? bus_b.busy         : bus_a.busy;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_credit"}, o_credit, 0);
    chk({tag, "_disp_req"}, o_disp_req, 0);
    chk({tag, "_chg_req"}, o_chg_req, 0);
    chk({tag, "_chg_coin"}, o_chg_coin, 0);
    chk({tag, "_reject"}, o_reject, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  // Insert a coin in IDLE/ACCUM, hold it, then idle the bus for 1+gap cycles.
  task automatic add_coin(input logic [1:0] code, input int hold, input int gap);
    int v;
    v = val_tab[code];
    moeda = code;
    tick();
    if (exp_credit + v <= MAXC) begin
      exp_credit += v;
      chk("coin_reject_ok", o_reject, 0);
    end else begin
      chk("coin_reject_cap", o_reject, 1);
    end
    chk("credit_update", o_credit, exp_credit);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("held_once", o_reject, 0);
    end
    moeda = 2'b00;
    repeat (1 + gap) tick();
  endtask

  // Pay out the expected credit as greedy coins, acking with random delay.
  task automatic do_change();
    int c, v, n, dly;
    logic [1:0] code;
    c = exp_credit;
    while (c > 0) begin
      if (c >= 25)      begin code = 2'b11; v = 25; end
      else if (c >= 10) begin code = 2'b10; v = 10; end
      else              begin code = 2'b01; v = 5;  end
      c -= v;
      n = 0;
      while (o_chg_req !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      chk("chg_req", o_chg_req, 1);
      chk("chg_coin", o_chg_coin, code);
      dly = int'($urandom_range(0, 2));
      repeat (dly) begin
        tick();
        chk("chg_hold", {o_chg_req, o_chg_coin}, {1'b1, code});
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      exp_credit -= v;
      chk("chg_drop", o_chg_req, 0);
      chk("chg_credit", o_credit, exp_credit);
      if (c > 0) begin
        tick();
        chk("chg_gap", o_chg_req, 1);
      end else begin
        chk("chg_done_busy", o_busy, 0);
      end
    end
  endtask

  // Device is in VEND; optionally poke a coin at it, then ack the dispense.
  task automatic do_vend(input logic poke);
    int dly;
    chk("disp_req", o_disp_req, 1);
    chk("vend_busy", o_busy, 1);
    exp_credit -= cur_price;
    chk("vend_credit", o_credit, exp_credit);
    if (poke) begin
      moeda = 2'b10;
      tick();
      chk("vend_reject", o_reject, 1);
      chk("vend_reject_credit", o_credit, exp_credit);
      tick();
      chk("reject_pulse", o_reject, 0);
      moeda = 2'b00;
      tick();
    end
    dly = int'($urandom_range(0, 3));
    repeat (dly) begin
      tick();
      chk("disp_hold", o_disp_req, 1);
    end
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
    chk("disp_drop", o_disp_req, 0);
    chk("post_vend_busy", o_busy, exp_credit > 0);
    if (exp_credit > 0) do_change();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", o_busy, 1);
    do_change();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check_all_zero("reset_a");
    sel = 1'b1;
    check_all_zero("reset_b");
    sel = 1'b0;

    // cancel with no credit is ignored
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    chk("idle_cancel_busy", o_busy, 0);
    chk("idle_cancel_req", o_chg_req, 0);

    // 5 + 10 + 10 -> vend, 5c change
    add_coin(2'b01, 2, 0);
    add_coin(2'b10, 2, 0);
    add_coin(2'b10, 2, 0);
    do_vend(1'b0);

    // exact price, no change
    add_coin(2'b10, 2, 0);
    add_coin(2'b10, 2, 0);
    do_vend(1'b0);
    repeat (3) begin
      tick();
      chk("exact_no_change", o_chg_req, 0);
    end

    // single 25 with a coin poked during VEND
    add_coin(2'b11, 2, 0);
    do_vend(1'b1);

    // refund of 10
    add_coin(2'b10, 2, 1);
    do_cancel();

    // 25 held for 4 cycles counts once
    add_coin(2'b11, 4, 0);
    do_vend(1'b0);

    // 5 followed directly by 10 with no idle gap: only the 5 counts
    moeda = 2'b01;
    tick();
    exp_credit = 5;
    chk("c2c_first", o_credit, exp_credit);
    tick();
    moeda = 2'b10;
    tick();
    tick();
    chk("c2c_second_credit", o_credit, exp_credit);
    chk("c2c_second_reject", o_reject, 0);
    moeda = 2'b00;
    tick();
    do_cancel();

    // cap at 95 on the high-priced copy, then multi-coin refund
    sel = 1'b1;
    cur_price = 100;
    add_coin(2'b11, 2, 0);
    add_coin(2'b11, 2, 0);
    add_coin(2'b11, 2, 0);
    add_coin(2'b10, 2, 0);
    add_coin(2'b10, 2, 0);
    add_coin(2'b01, 2, 0);
    add_coin(2'b11, 2, 0);
    chk("cap_credit", o_credit, 95);
    do_cancel();
    sel = 1'b0;
    cur_price = 20;

    // reset while a change coin is presented
    add_coin(2'b11, 2, 0);
    exp_credit -= cur_price;
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
    chk("pre_rst_chg_req", o_chg_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_credit = 0;
    check_all_zero("mid_change_rst");
    add_coin(2'b01, 2, 0);
    do_cancel();

    // randomized purchases and refunds
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 10; k++) begin
        add_coin(2'($urandom_range(1, 3)), int'($urandom_range(2, 4)), int'($urandom_range(0, 2)));
        if (exp_credit >= cur_price) begin
          do_vend(1'($urandom_range(0, 1)));
          break;
        end
        if ($urandom_range(0, 3) == 0) begin
          do_cancel();
          break;
        end
      end
      if (exp_credit > 0) do_cancel();
      chk("txn_end_credit", o_credit, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
